// File: rtl/pipeline_pkg.sv
// Shared definitions for the IF/OF/EX/MA/RW pipeline hazard controller:
// field positions, special words, FSM states and the source-use decoder.
package pipeline_pkg;

  localparam int unsigned OP_LSB  = 8;
  localparam int unsigned RS1_LSB = 12;
  localparam int unsigned RS2_LSB = 16;

  localparam logic [23:0] NOP_IFOF    = 24'h000800;
  localparam logic [23:0] BUBBLE_OFEX = 24'h000100;
  localparam logic [3:0]  FLAG_REG    = 4'd15;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StStall = 2'd1,
    StFlush = 2'd2
  } state_e;

  typedef struct packed {
    logic reads_rs1;
    logic reads_rs2;
    logic reads_flag;
  } src_use_t;

  function automatic src_use_t src_use(input logic [3:0] op);
    src_use_t u;
    u.reads_rs1  = ~op[3] | (op[1:0] == 2'b10);
    u.reads_rs2  = ~op[3] & (op[1:0] != 2'b11);
    u.reads_flag = (op == 4'b1011);
    return u;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// Per-register countdown of in-flight writes; busy_o[r] is set while r is not
// yet readable by OF.
module hazard_scoreboard
  import pipeline_pkg::*;
#(
  parameter int unsigned WB_LAT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        set_i,
  input  logic [3:0]  set_addr_i,
  output logic [15:0] busy_o
);

  // RW writes before OF reads in the same cycle, so only WB_LAT-1 cycles block.
  localparam logic [1:0] LoadVal = 2'(WB_LAT - 1);

  logic [15:0][1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    busy_o = '0;
    for (int r = 0; r < 16; r++) begin
      busy_o[r] = (busy_q[r] != 2'd0);
      busy_d[r] = (busy_q[r] != 2'd0) ? busy_q[r] - 2'd1 : 2'd0;
      if (set_i && (set_addr_i == 4'(r))) begin
        busy_d[r] = LoadVal;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Issue/stall/flush controller for the OF stage with stall and flush
// performance counters.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned WB_LAT       = 3,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             of_valid_i,
  input  logic [23:0]      of_instr_i,
  input  logic             of_wr_en_i,
  input  logic [3:0]       of_wr_addr_i,
  input  logic             ex_branch_taken_i,
  output logic             issue_o,
  output logic             pc_hold_o,
  output logic             ifof_hold_o,
  output logic             ifof_flush_o,
  output logic             ofex_bubble_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_events_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [3:0]  op, rs1, rs2;
  src_use_t    use_s;
  logic [15:0] busy;
  logic        hazard;
  logic        unused_instr;

  assign op           = of_instr_i[OP_LSB +: 4];
  assign rs1          = of_instr_i[RS1_LSB +: 4];
  assign rs2          = of_instr_i[RS2_LSB +: 4];
  assign unused_instr = ^{of_instr_i[23:20], of_instr_i[7:0]};
  assign use_s        = src_use(op);

  assign hazard = of_valid_i & ((use_s.reads_rs1 & busy[rs1]) |
                                (use_s.reads_rs2 & busy[rs2]) |
                                (use_s.reads_flag & busy[FLAG_REG]));

  hazard_scoreboard #(
    .WB_LAT (WB_LAT)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_i      (issue_o & of_wr_en_i),
    .set_addr_i (of_wr_addr_i),
    .busy_o     (busy)
  );

  state_e           state_q, state_d;
  logic [1:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;

  always_comb begin
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    issue_o       = 1'b0;
    pc_hold_o     = 1'b0;
    ifof_hold_o   = 1'b0;
    ifof_flush_o  = 1'b0;
    ofex_bubble_o = 1'b0;
    if (ex_branch_taken_i) begin
      ifof_flush_o  = 1'b1;
      ofex_bubble_o = 1'b1;
      state_d       = StFlush;
      fcnt_d        = 2'(FLUSH_CYCLES);
    end else if (state_q == StFlush) begin
      ifof_flush_o  = 1'b1;
      ofex_bubble_o = 1'b1;
      fcnt_d        = fcnt_q - 2'd1;
      if (fcnt_q <= 2'd1) begin
        state_d = StRun;
      end
    end else if (hazard) begin
      pc_hold_o     = 1'b1;
      ifof_hold_o   = 1'b1;
      ofex_bubble_o = 1'b1;
      state_d       = StStall;
    end else begin
      issue_o = of_valid_i;
      state_d = StRun;
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (pc_hold_o && (stall_q != CntMax)) begin
      stall_d = stall_q + 1'b1;
    end
    if (ex_branch_taken_i && (flush_q != CntMax)) begin
      flush_d = flush_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      fcnt_q  <= 2'd0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign state_o        = state_q;
  assign stall_cycles_o = stall_q;
  assign flush_events_o = flush_q;

endmodule
